// File: rtl/lifo_fifo_buf_if.sv
// ---------------------------------------------------------------------------
// lifo_fifo_buf_if
// Purpose : Groups the producer/consumer side signals of lifo_fifo_buf into
//           one bundle so the buffer and its user connect through a single
//           port.
// Signals : mode         - requested mode, 0 = FIFO, 1 = LIFO
//           wr_en        - write request
//           wr_data      - write data
//           rd_en        - read request
//           rd_data      - registered read data
//           rd_val       - rd_data holds the result of last cycle's read
//           wr_ready     - buffer is not full
//           count        - current occupancy, 0..DEPTH
//           almost_full  - count >= AF_LEVEL
//           almost_empty - count <= AE_LEVEL
//           overflow     - sticky, a write was dropped
//           underflow    - sticky, a read found the buffer empty
//           active_mode  - mode currently in force
// Modports: master - the producer/consumer side
//           slave  - the buffer itself
// ---------------------------------------------------------------------------
interface lifo_fifo_buf_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);

  localparam int CW = $clog2(DEPTH + 1);

  logic                  mode;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_val;
  logic                  wr_ready;
  logic [CW-1:0]         count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic                  active_mode;

  // The user drives requests and observes the buffer status.
  modport master (
    output mode, wr_en, wr_data, rd_en,
    input  rd_data, rd_val, wr_ready, count, almost_full, almost_empty,
           overflow, underflow, active_mode
  );

  // The buffer consumes requests and drives its status.
  modport slave (
    input  mode, wr_en, wr_data, rd_en,
    output rd_data, rd_val, wr_ready, count, almost_full, almost_empty,
           overflow, underflow, active_mode
  );

endinterface

// File: rtl/lifo_fifo_buf.sv
// ---------------------------------------------------------------------------
// lifo_fifo_buf
// Purpose : Parametrised storage buffer that runs either as a queue (FIFO)
//           or as a stack (LIFO), chosen at run time. The mode can only
//           change while the buffer is empty. Reads have one cycle of
//           latency through a registered output. The buffer also reports
//           its occupancy, almost-full/almost-empty levels and sticky
//           overflow/underflow flags.
// Ports   : i_clk   - single clock, all logic on the rising edge
//           i_reset - synchronous, active-high reset
//           bus     - lifo_fifo_buf_if.slave carrying the requests, read
//                     data and status (see the interface file)
// ---------------------------------------------------------------------------
module lifo_fifo_buf #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  lifo_fifo_buf_if.slave    bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_COUNT   = CW'(AE_LEVEL);

  // Storage and state registers
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wrPtr;
  logic [PW-1:0]         r_rdPtr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_rdData;
  logic                  r_rdVal;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_activeMode;

  // Per-cycle decisions
  logic                  w_empty;
  logic                  w_full;
  logic                  w_mode;
  logic                  w_rdValid;
  logic                  w_wrAccept;
  logic                  w_overflowEvt;
  logic                  w_underflowEvt;
  logic [PW-1:0]         w_topPtr;
  logic [PW-1:0]         w_wrAddr;
  logic [PW-1:0]         w_rdAddr;
  logic [PW-1:0]         w_wrPtrNext;
  logic [PW-1:0]         w_rdPtrNext;

  // Pointers wrap modulo DEPTH, which does not have to be a power of two,
  // so the wrap is an explicit compare rather than a natural overflow.
  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptrDec(input logic [PW-1:0] p);
    return (p == '0) ? LAST_PTR : p - 1'b1;
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);

  // A mode request only lands on an empty buffer, and that same cycle
  // already uses it. Otherwise the latched mode stays in force.
  assign w_mode = w_empty ? bus.mode : r_activeMode;

  // A read is real only when something is stored. A write is accepted
  // unless the buffer is full with no read freeing a slot in the same
  // cycle.
  assign w_rdValid      = bus.rd_en && !w_empty;
  assign w_wrAccept     = bus.wr_en && (!w_full || bus.rd_en);
  assign w_overflowEvt  = bus.wr_en && w_full && !bus.rd_en;
  assign w_underflowEvt = bus.rd_en && w_empty;

  // In LIFO mode the top of stack sits one slot below wr_ptr. When a push
  // and a pop happen together, the pop returns the old top and the new
  // data overwrites that same slot, so wr_ptr does not move.
  assign w_topPtr = ptrDec(r_wrPtr);
  assign w_wrAddr = (w_mode && w_rdValid) ? w_topPtr : r_wrPtr;
  assign w_rdAddr = w_mode ? w_topPtr : r_rdPtr;

  // Next-pointer selection. In FIFO mode rd_ptr is pulled onto wr_ptr
  // whenever the buffer is empty. A LIFO session only moves wr_ptr, which
  // leaves rd_ptr stale, and this keeps the head correct after a later
  // switch back to FIFO.
  always_comb begin
    w_wrPtrNext = r_wrPtr;
    w_rdPtrNext = r_rdPtr;
    if (w_mode) begin
      if (w_wrAccept && !w_rdValid) begin
        w_wrPtrNext = ptrInc(r_wrPtr);
      end else if (w_rdValid && !w_wrAccept) begin
        w_wrPtrNext = w_topPtr;
      end
    end else begin
      if (w_wrAccept) begin
        w_wrPtrNext = ptrInc(r_wrPtr);
      end
      if (w_empty) begin
        w_rdPtrNext = r_wrPtr;
      end else if (w_rdValid) begin
        w_rdPtrNext = ptrInc(r_rdPtr);
      end
    end
  end

  // Storage array. It is not reset because its contents are don't-care
  // until written. Reset still blocks writes so that reset dominates.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wrAccept) begin
      r_mem[w_wrAddr] <= bus.wr_data;
    end
  end

  // Control state: pointers, occupancy, registered read port, sticky
  // error flags and the latched mode. The read samples the array before
  // this cycle's write lands, so a combined push/pop returns the old
  // entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_rdData     <= '0;
      r_rdVal      <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_activeMode <= 1'b0;
    end else begin
      r_wrPtr <= w_wrPtrNext;
      r_rdPtr <= w_rdPtrNext;
      r_rdVal <= w_rdValid;
      if (w_empty) begin
        r_activeMode <= bus.mode;
      end
      if (w_rdValid) begin
        r_rdData <= r_mem[w_rdAddr];
      end
      if (w_wrAccept && !w_rdValid) begin
        r_count <= r_count + 1'b1;
      end else if (w_rdValid && !w_wrAccept) begin
        r_count <= r_count - 1'b1;
      end
      if (w_overflowEvt) begin
        r_overflow <= 1'b1;
      end
      if (w_underflowEvt) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Status outputs. The level flags and wr_ready follow the registered
  // count combinationally.
  assign bus.rd_data      = r_rdData;
  assign bus.rd_val       = r_rdVal;
  assign bus.count        = r_count;
  assign bus.wr_ready     = !w_full;
  assign bus.almost_full  = (r_count >= AF_COUNT);
  assign bus.almost_empty = (r_count <= AE_COUNT);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
  assign bus.active_mode  = r_activeMode;

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// ---------------------------------------------------------------------------
// tb_lifo_fifo_buf
// Purpose : Directed test of lifo_fifo_buf. An 8-deep instance covers
//           reset, FIFO and LIFO ordering, full/overflow, the combined
//           push/pop and the mode switch. A 5-deep instance in FIFO mode
//           is checked against a reference queue so the pointers wrap
//           several times.
// ---------------------------------------------------------------------------
module tb_lifo_fifo_buf;

  logic clk = 1'b0;
  logic rst8;
  logic rst5;

  int checks   = 0;
  int failures = 0;

  lifo_fifo_buf_if #(.DATA_WIDTH(8), .DEPTH(8)) bus8 ();
  lifo_fifo_buf_if #(.DATA_WIDTH(8), .DEPTH(5)) bus5 ();

  lifo_fifo_buf #(.DEPTH(8), .DATA_WIDTH(8)) u_dut8 (
    .i_clk   (clk),
    .i_reset (rst8),
    .bus     (bus8)
  );

  lifo_fifo_buf #(.DEPTH(5), .DATA_WIDTH(8)) u_dut5 (
    .i_clk   (clk),
    .i_reset (rst5),
    .bus     (bus5)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // One comparison with its own assertion. A failure is counted, reported
  // on a FAIL line, and also raised through $error.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] check %s failed", tag);
    end
  endtask

  // Checks the count, rd_val and rd_data of the 8-deep instance together.
  task automatic checkReadPort(input string tag, input int expCount,
                               input logic expVal, input logic [7:0] expData);
    checkOutput({tag, ".count"},   32'(bus8.count),   32'(expCount));
    checkOutput({tag, ".rd_val"},  32'(bus8.rd_val),  32'(expVal));
    checkOutput({tag, ".rd_data"}, 32'(bus8.rd_data), 32'(expData));
  endtask

  // Drives one cycle of requests into the 8-deep instance and samples
  // 1 time unit after the rising edge.
  task automatic applyStimulus(input logic m, input logic w,
                               input logic [7:0] d, input logic r);
    bus8.mode    = m;
    bus8.wr_en   = w;
    bus8.wr_data = d;
    bus8.rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] lastData;
    logic [7:0] d;
    logic       w;
    logic       r;
    logic       expVal;
    logic [7:0] expData;
    logic       expOvf;
    logic       expUdf;
    int         cnt;
    int         reads;

    rst8 = 1'b1;
    rst5 = 1'b1;
    bus8.mode = 1'b0; bus8.wr_en = 1'b1; bus8.wr_data = 8'hAA; bus8.rd_en = 1'b0;
    bus5.mode = 1'b0; bus5.wr_en = 1'b0; bus5.wr_data = 8'h00; bus5.rd_en = 1'b0;

    // Reset dominates a pending write
    @(posedge clk);
    @(posedge clk);
    #1;
    checkReadPort("reset", 0, 1'b0, 8'h00);
    checkOutput("reset.overflow",     32'(bus8.overflow),     32'd0);
    checkOutput("reset.underflow",    32'(bus8.underflow),    32'd0);
    checkOutput("reset.active_mode",  32'(bus8.active_mode),  32'd0);
    checkOutput("reset.wr_ready",     32'(bus8.wr_ready),     32'd1);
    checkOutput("reset.almost_empty", 32'(bus8.almost_empty), 32'd1);
    checkOutput("reset.almost_full",  32'(bus8.almost_full),  32'd0);
    rst8 = 1'b0;

    // Read while empty
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkReadPort("empty_read", 0, 1'b0, 8'h00);
    checkOutput("empty_read.underflow", 32'(bus8.underflow), 32'd1);

    // FIFO fill 1..8
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
      checkOutput($sformatf("fifo_fill%0d.count", i), 32'(bus8.count), 32'(i));
      if (i == 5) checkOutput("fifo_fill5.almost_full", 32'(bus8.almost_full), 32'd0);
      if (i == 6) checkOutput("fifo_fill6.almost_full", 32'(bus8.almost_full), 32'd1);
      if (i == 7) checkOutput("fifo_fill7.wr_ready",    32'(bus8.wr_ready),    32'd1);
    end
    checkOutput("fifo_full.wr_ready",     32'(bus8.wr_ready),     32'd0);
    checkOutput("fifo_full.almost_full",  32'(bus8.almost_full),  32'd1);
    checkOutput("fifo_full.almost_empty", 32'(bus8.almost_empty), 32'd0);

    // FIFO drain in write order
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkReadPort($sformatf("fifo_read%0d", i), 8 - i, 1'b1, 8'(i));
    end
    checkOutput("fifo_empty.almost_empty", 32'(bus8.almost_empty), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkReadPort("fifo_idle", 0, 1'b0, 8'h08);

    // LIFO push/pop after a fresh reset
    rst8 = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    rst8 = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h10, 1'b0);
    checkOutput("lifo.active_mode", 32'(bus8.active_mode), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h20, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h30, 1'b0);
    checkReadPort("lifo_push3", 3, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkReadPort("lifo_pop1", 2, 1'b1, 8'h30);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkReadPort("lifo_pop2", 1, 1'b1, 8'h20);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkReadPort("lifo_pop3", 0, 1'b1, 8'h10);
    checkOutput("lifo_pop3.underflow", 32'(bus8.underflow), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkReadPort("lifo_pop4", 0, 1'b0, 8'h10);
    checkOutput("lifo_pop4.underflow", 32'(bus8.underflow), 32'd1);

    // Full LIFO: overflow, combined push/pop, then pop the replaced top
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i), 1'b0);
    end
    checkOutput("lifo_full.count",    32'(bus8.count),    32'd8);
    checkOutput("lifo_full.overflow", 32'(bus8.overflow), 32'd0);
    applyStimulus(1'b1, 1'b1, 8'h99, 1'b0);
    checkReadPort("lifo_ovf", 8, 1'b0, 8'h10);
    checkOutput("lifo_ovf.overflow", 32'(bus8.overflow), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b1);
    checkReadPort("lifo_swap", 8, 1'b1, 8'h08);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkReadPort("lifo_pop_new", 7, 1'b1, 8'h77);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkReadPort("lifo_pop_next", 6, 1'b1, 8'h07);

    // Mode switch only takes effect once the buffer has drained
    rst8 = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    rst8 = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h02, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("switch_held.active_mode", 32'(bus8.active_mode), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkReadPort("switch_drain1", 1, 1'b1, 8'h01);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkReadPort("switch_drain2", 0, 1'b1, 8'h02);
    checkOutput("switch_drain2.active_mode", 32'(bus8.active_mode), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("switch_done.active_mode", 32'(bus8.active_mode), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h0A, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h0B, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkReadPort("switch_pop1", 1, 1'b1, 8'h0B);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkReadPort("switch_pop2", 0, 1'b1, 8'h0A);
    checkOutput("switch.underflow", 32'(bus8.underflow), 32'd0);

    // Write and read together on an empty buffer: no bypass
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b1);
    checkReadPort("empty_wr_rd", 1, 1'b0, 8'h0A);
    checkOutput("empty_wr_rd.underflow", 32'(bus8.underflow), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkReadPort("empty_wr_rd_pop", 0, 1'b1, 8'h55);

    // 5-deep FIFO with random traffic against a reference queue
    @(posedge clk);
    #1;
    rst5 = 1'b0;
    lastData = 8'h00;
    expOvf   = 1'b0;
    expUdf   = 1'b0;
    reads    = 0;
    for (int c = 0; c < 60; c++) begin
      w = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 7);
      d = 8'($urandom_range(0, 255));
      cnt = q.size();
      expVal  = r && (cnt > 0);
      expData = lastData;
      if (expVal) begin
        expData = q.pop_front();
        reads++;
      end
      if (w && (cnt < 5 || r)) q.push_back(d);
      if (w && cnt == 5 && !r) expOvf = 1'b1;
      if (r && cnt == 0) expUdf = 1'b1;
      lastData = expData;

      bus5.wr_en   = w;
      bus5.rd_en   = r;
      bus5.wr_data = d;
      @(posedge clk);
      #1;
      checkOutput($sformatf("wrap%0d.count", c),        32'(bus5.count),        32'(q.size()));
      checkOutput($sformatf("wrap%0d.almost_full", c),  32'(bus5.almost_full),  32'(q.size() >= 3));
      checkOutput($sformatf("wrap%0d.almost_empty", c), 32'(bus5.almost_empty), 32'(q.size() <= 2));
      checkOutput($sformatf("wrap%0d.wr_ready", c),     32'(bus5.wr_ready),     32'(q.size() != 5));
      checkOutput($sformatf("wrap%0d.rd_val", c),       32'(bus5.rd_val),       32'(expVal));
      checkOutput($sformatf("wrap%0d.rd_data", c),      32'(bus5.rd_data),      32'(expData));
    end
    checkOutput("wrap.overflow",  32'(bus5.overflow),  32'(expOvf));
    checkOutput("wrap.underflow", 32'(bus5.underflow), 32'(expUdf));
    $display("[TB] wrap test issued %0d valid reads", reads);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
